gb_timer: RTL
=============

GB_TIMER -- requirements
Module: gb_timer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock, shared with sm83_core.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port addr, input, addr_t: CPU bus address; read and write share this address.
REQ-004 The block SHALL have the port w_data, input, data_t: CPU write data.
REQ-005 The block SHALL have the port w_wen, input, 1 bit: CPU write strobe, qualified internally by sel.
REQ-006 The block SHALL have the port r_data, output, data_t: combinational read data; 0x00 when sel=0.
REQ-007 The block SHALL have the port sel, output, 1 bit: combinational; high iff addr is in 0xFF04..0xFF07; used by the top-level read mux.
REQ-008 The block SHALL have the port irq_timer, output, 1 bit: registered timer interrupt request, a one-clk pulse.

Function
REQ-009 The block SHALL keep a 16-bit internal counter, sys_cnt, that increments by 1 every clk and wraps 0xFFFF->0x0000.
REQ-010 A read of DIV (0xFF04) SHALL return sys_cnt[15:8]; any write to DIV SHALL clear sys_cnt to 0x0000 on the next edge (the data value is ignored).
REQ-011 The block SHALL hold TIMA (0xFF05), TMA (0xFF06) and TAC (0xFF07, 3 bits) registers; a TAC read SHALL return {5'b11111, tac[2:0]}.
REQ-012 Tap bit selection SHALL be tac[1:0]: 00->sys_cnt[9], 01->sys_cnt[3], 10->sys_cnt[5], 11->sys_cnt[7].
REQ-013 The timer input SHALL be tap = tac[2] AND selected sys_cnt bit; TIMA SHALL increment on every 1->0 transition of tap, registered and compared against the previous cycle.
REQ-014 As a consequence of REQ-013, a DIV write while tap=1 SHALL cause one TIMA increment, and so SHALL a TAC write that drops tap from 1 to 0.
REQ-015 The state machine SHALL be timer_state_t with states RUN, OVF and RELOAD.
REQ-016 In RUN, an increment of TIMA from 0xFF SHALL set TIMA to 0x00 and move to OVF.
REQ-017 In OVF (exactly 1 clk), TIMA SHALL read 0x00. A CPU write to TIMA in this cycle SHALL load w_data, cancel the reload and the IRQ, and return to RUN. Otherwise the state SHALL go to RELOAD.
REQ-018 In RELOAD (exactly 1 clk), TIMA SHALL be loaded with TMA, irq_timer SHALL be 1 for this cycle only, and the state SHALL return to RUN.
REQ-019 A TMA write during RELOAD SHALL load TIMA with the new w_data, and TMA SHALL also take it.
REQ-020 A TIMA write during RELOAD SHALL be ignored.
REQ-021 A TIMA write in RUN coincident with an increment: the write SHALL win and the increment SHALL be lost.
REQ-022 Tap falling edges during OVF or RELOAD SHALL be ignored.
REQ-023 Writes outside 0xFF04..0xFF07 SHALL have no effect; reads SHALL have no side effects.

Reset
REQ-024 On rst_n=0, the block SHALL asynchronously clear sys_cnt, TIMA, TMA and TAC to 0, clear the tap history to 0, set the state to RUN and drive irq_timer=0.
REQ-025 Reset asserted during OVF or RELOAD SHALL abort the reload with no IRQ pulse, either during reset or after release.
REQ-026 The first sys_cnt increment SHALL occur on the first clk edge after rst_n deasserts.

Structure
REQ-027 sm83_pkg SHALL hold the constants TIMER_DIV_ADDR, TIMER_TIMA_ADDR, TIMER_TMA_ADDR and TIMER_TAC_ADDR, and the enum timer_state_t.
REQ-028 The block SHALL be a single module with no sub-module; it SHALL be instantiated in the top level beside WRAM0, with r_data muxed in via sel at highest priority.

Verification
REQ-029 Reset, run 0x0300 clk, read 0xFF04 -> 0x03; write 0xFF04=0x5A, then read -> 0x00, and sys_cnt==1 one clk later.
REQ-030 TAC=0x05, TIMA=0x00, count from a DIV write -> TIMA==0x01 after 16 clk and 0x04 after 64 clk; TAC=0x01 -> TIMA frozen.
REQ-031 TMA=0xAB, TIMA=0xFF, TAC=0x05 -> at overflow TIMA reads 0x00 for 1 clk, then 0xAB; irq_timer high exactly 1 clk, coincident with RELOAD.
REQ-032 Same setup, write TIMA=0x10 during OVF -> TIMA==0x10, no irq_timer pulse; write TMA=0x77 during RELOAD -> TIMA==0x77, IRQ still fires.
REQ-033 TAC=0x05 with sys_cnt[3]=1, then write DIV -> TIMA +1; write TAC=0x01 with tap=1 -> TIMA +1.
REQ-034 Assert rst_n during OVF -> all registers 0, state RUN, and no irq_timer pulse after release.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared SM83 system types and timer register map.
// Holds the bus types, the timer address constants and the timer state enum.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    localparam addr_t TIMER_DIV_ADDR  = 16'hFF04;
    localparam addr_t TIMER_TIMA_ADDR = 16'hFF05;
    localparam addr_t TIMER_TMA_ADDR  = 16'hFF06;
    localparam addr_t TIMER_TAC_ADDR  = 16'hFF07;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } timer_state_t;

endpackage

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer: free-running divider, tap falling-edge
// counter and delayed TMA reload with a one-clock interrupt pulse.
module gb_timer
    import sm83_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  addr_t addr,
    input  data_t w_data,
    input  logic  w_wen,
    output data_t r_data,
    output logic  sel,
    output logic  irq_timer
);

    logic [15:0]  sys_cnt_q, sys_cnt_d;
    data_t        tima_q, tima_d;
    data_t        tma_q, tma_d;
    logic [2:0]   tac_q, tac_d;
    logic         tap_prev_q, tap_prev_d;
    logic         irq_q, irq_d;
    timer_state_t state_q, state_d;

    logic tap_bit;
    logic tap;
    logic tap_fall;
    logic wr_div, wr_tima, wr_tma, wr_tac;

    assign sel = (addr >= TIMER_DIV_ADDR) && (addr <= TIMER_TAC_ADDR);

    assign wr_div  = w_wen && sel && (addr == TIMER_DIV_ADDR);
    assign wr_tima = w_wen && sel && (addr == TIMER_TIMA_ADDR);
    assign wr_tma  = w_wen && sel && (addr == TIMER_TMA_ADDR);
    assign wr_tac  = w_wen && sel && (addr == TIMER_TAC_ADDR);

    always_comb begin
        tap_bit = 1'b0;
        case (tac_q[1:0])
            2'b00:   tap_bit = sys_cnt_q[9];
            2'b01:   tap_bit = sys_cnt_q[3];
            2'b10:   tap_bit = sys_cnt_q[5];
            default: tap_bit = sys_cnt_q[7];
        endcase
    end

    // Edge detection uses the registered tap, so a DIV clear or TAC change that
    // drops the tap also produces a count, exactly like a natural falling edge.
    assign tap      = tac_q[2] & tap_bit;
    assign tap_fall = tap_prev_q & ~tap;

    always_comb begin
        sys_cnt_d  = wr_div ? 16'h0000 : sys_cnt_q + 16'd1;
        tma_d      = wr_tma ? w_data : tma_q;
        tac_d      = wr_tac ? w_data[2:0] : tac_q;
        tap_prev_d = tap;
        tima_d     = tima_q;
        state_d    = state_q;
        irq_d      = 1'b0;

        case (state_q)
            RUN: begin
                if (wr_tima) begin
                    tima_d = w_data;
                end else if (tap_fall) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = OVF;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            OVF: begin
                if (wr_tima) begin
                    tima_d  = w_data;
                    state_d = RUN;
                end else begin
                    // TIMA shows TMA for the whole RELOAD cycle; the pulse lines up with it.
                    tima_d  = tma_d;
                    state_d = RELOAD;
                    irq_d   = 1'b1;
                end
            end
            RELOAD: begin
                tima_d  = tma_d;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_cnt_q  <= 16'h0000;
            tima_q     <= 8'h00;
            tma_q      <= 8'h00;
            tac_q      <= 3'b000;
            tap_prev_q <= 1'b0;
            irq_q      <= 1'b0;
            state_q    <= RUN;
        end else begin
            sys_cnt_q  <= sys_cnt_d;
            tima_q     <= tima_d;
            tma_q      <= tma_d;
            tac_q      <= tac_d;
            tap_prev_q <= tap_prev_d;
            irq_q      <= irq_d;
            state_q    <= state_d;
        end
    end

    assign irq_timer = irq_q;

    always_comb begin
        r_data = 8'h00;
        if (sel) begin
            case (addr)
                TIMER_DIV_ADDR:  r_data = sys_cnt_q[15:8];
                TIMER_TIMA_ADDR: r_data = tima_q;
                TIMER_TMA_ADDR:  r_data = tma_q;
                TIMER_TAC_ADDR:  r_data = {5'b11111, tac_q};
                default:         r_data = 8'h00;
            endcase
        end
    end

endmodule
